ones_pattern_gen: RTL and testbench

Sequential stimulus source producing a 63-bit word with exactly K ones at pseudo-random positions: the inverse of the 63-input ones counter (count in, pattern out). It sits ahead of the ones-counter datapath in bench and self-test harnesses. It accepts a 6-bit weight K and seed over a valid/ready handshake, sets one bit per cycle at positions walked by a 6-bit maximal LFSR, then presents the word over a second valid/ready handshake.

---
 rtl/ones_gen_pkg.sv | 21 ++
 rtl/ones_pattern_gen_if.sv | 29 ++
 rtl/ones_popcount63.sv | 26 ++
 rtl/ones_pattern_gen.sv | 118 +++++++++++
 tb/tb_ones_pattern_gen.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/ones_gen_pkg.sv
// Shared types, sizes and helpers for the K-ones pattern generator.
package ones_gen_pkg;

  localparam int WIDTH = 63;
  localparam int CW    = 6;

  // Zero would lock the LFSR, so any override must stay nonzero.
  localparam logic [CW-1:0] DEFAULT_SEED_DFLT = 6'h01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  // x^6 + x^5 + 1 Fibonacci step: walks all 63 nonzero states.
  function automatic logic [CW-1:0] lfsr_next(input logic [CW-1:0] s);
    return {s[4:0], s[5] ^ s[4]};
  endfunction

endpackage

// File: rtl/ones_pattern_gen_if.sv
// Request and result channels of the K-ones pattern generator.
interface ones_pattern_gen_if;
  import ones_gen_pkg::*;

  // Both channels: a transfer happens on a rising clk edge where valid and
  // ready are both high; valid never drops, nor does its payload change,
  // until that transfer has happened.
  logic            req_valid;
  logic            req_ready;
  logic [CW-1:0]   req_k;
  logic [CW-1:0]   req_seed;
  logic            out_valid;
  logic            out_ready;
  logic [WIDTH-1:0] out_word;
  logic [CW-1:0]   out_k;
  logic            busy;
  state_t          dbg_state;

  modport slave (
    input  req_valid, req_k, req_seed, out_ready,
    output req_ready, out_valid, out_word, out_k, busy, dbg_state
  );

  modport master (
    output req_valid, req_k, req_seed, out_ready,
    input  req_ready, out_valid, out_word, out_k, busy, dbg_state
  );

endinterface

// File: rtl/ones_popcount63.sv
// Combinational 63-bit population count; only used when ONES_GEN_SELFCHECK_EN is defined.
module ones_popcount63
  import ones_gen_pkg::*;
(
  input  logic [WIDTH-1:0] i_word,
  output logic [CW-1:0]    o_count
);

  logic [2:0] w_grp [9];
  logic [4:0] w_tri [3];

  // Nine 7-bit groups, then three sums of three groups, then the final add.
  always_comb begin
    for (int g = 0; g < 9; g++) begin
      w_grp[g] = '0;
      for (int b = 0; b < 7; b++) begin
        w_grp[g] = w_grp[g] + {2'b00, i_word[g*7+b]};
      end
    end
    for (int t = 0; t < 3; t++) begin
      w_tri[t] = {2'b00, w_grp[3*t]} + {2'b00, w_grp[3*t+1]} + {2'b00, w_grp[3*t+2]};
    end
    o_count = {1'b0, w_tri[0]} + {1'b0, w_tri[1]} + {1'b0, w_tri[2]};
  end

endmodule

// File: rtl/ones_pattern_gen.sv
// Produces a 63-bit word with exactly K ones at LFSR-walked positions.
// Optional ONES_GEN_SELFCHECK_EN adds a sticky chk_err popcount check.
module ones_pattern_gen
  import ones_gen_pkg::*;
#(
  parameter logic [CW-1:0] DEFAULT_SEED = DEFAULT_SEED_DFLT
) (
  input  logic                clk,
  input  logic                rst,
  ones_pattern_gen_if.slave   bus
`ifdef ONES_GEN_SELFCHECK_EN
  ,
  output logic                chk_err
`endif
);

  state_t           r_state;
  logic [CW-1:0]    r_lfsr;
  logic [CW-1:0]    r_remaining;
  logic [CW-1:0]    r_out_k;
  logic [WIDTH-1:0] r_word;
  logic             r_req_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic [CW-1:0]    w_load_seed;
  logic [CW-1:0]    w_bit_idx;
  logic [WIDTH-1:0] w_set_mask;

  assign w_load_seed = (bus.req_seed == '0) ? DEFAULT_SEED : bus.req_seed;
  // LFSR state s (1..63) marks bit s-1, so every position is reachable.
  assign w_bit_idx   = r_lfsr - 6'd1;
  assign w_set_mask  = {{(WIDTH-1){1'b0}}, 1'b1} << w_bit_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_lfsr      <= DEFAULT_SEED;
      r_remaining <= '0;
      r_out_k     <= '0;
      r_word      <= '0;
      r_req_ready <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_out_k     <= bus.req_k;
            r_lfsr      <= w_load_seed;
            r_word      <= '0;
            r_remaining <= bus.req_k;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (bus.req_k != '0) begin
              r_state <= FILL;
            end else begin
              r_state     <= HOLD;
              r_out_valid <= 1'b1;
            end
          end
        end
        FILL: begin
          r_word      <= r_word | w_set_mask;
          r_lfsr      <= lfsr_next(r_lfsr);
          r_remaining <= r_remaining - 6'd1;
          if (r_remaining == 6'd1) begin
            r_state     <= HOLD;
            r_out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_word  = r_word;
  assign bus.out_k     = r_out_k;
  assign bus.busy      = r_busy;
  assign bus.dbg_state = r_state;

`ifdef ONES_GEN_SELFCHECK_EN
  logic [CW-1:0] w_pop;
  logic          r_chk_err;

  ones_popcount63 u_popcount (
    .i_word  (r_word),
    .o_count (w_pop)
  );

  // Sticky: any HOLD cycle whose word weight disagrees with K latches the flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_chk_err <= 1'b0;
    end else if (r_state == HOLD && w_pop != r_out_k) begin
      r_chk_err <= 1'b1;
    end
  end

  assign chk_err = r_chk_err;
`endif

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Bench for ones_pattern_gen: directed vectors, cycle-level model, K sweep.
module tb_ones_pattern_gen;
  import ones_gen_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ones_pattern_gen_if bus ();

`ifdef ONES_GEN_SELFCHECK_EN
  logic chk_err;
`endif

  ones_pattern_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ONES_GEN_SELFCHECK_EN
    ,
    .chk_err (chk_err)
`endif
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_on = 1'b0;

  logic [62:0] exp_q [$];

  // Model: request-level view (idle flag, word, K, cycle HOLD begins).
  bit          m_idle = 1'b1;
  logic [62:0] m_word = '0;
  logic [5:0]  m_k    = '0;
  int          m_hold_from = 0;
  bit          e_hold;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Word with K ones at positions s-1 visited by the LFSR from the seed.
  function automatic logic [62:0] gen_word(input int k, input int seed);
    logic [62:0] w;
    int s;
    w = '0;
    s = (seed == 0) ? 1 : seed;
    for (int i = 0; i < k; i++) begin
      w[s-1] = 1'b1;
      s = ((s * 2) % 64) | (((s >> 5) ^ (s >> 4)) & 1);
    end
    return w;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_idle <= 1'b1;
      m_word <= '0;
      m_k    <= '0;
    end else if (m_idle) begin
      if (bus.req_valid) begin
        m_idle      <= 1'b0;
        m_k         <= bus.req_k;
        m_word      <= gen_word(int'(bus.req_k), int'(bus.req_seed));
        m_hold_from <= cyc + int'(bus.req_k) + 1;
      end
    end else if (cyc >= m_hold_from && bus.out_ready) begin
      m_idle <= 1'b1;
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      e_hold = !m_idle && (cyc >= m_hold_from);
      check("cyc_req_ready", bus.req_ready, m_idle);
      check("cyc_busy", bus.busy, !m_idle);
      check("cyc_out_valid", bus.out_valid, e_hold);
      check("cyc_out_k", bus.out_k, m_k);
      if (m_idle || e_hold) check("cyc_out_word", bus.out_word, m_word);
`ifdef ONES_GEN_SELFCHECK_EN
      check("cyc_chk_err", chk_err, 1'b0);
`endif
    end
  end

  task automatic run_req(input int k, input int seed, input int stall,
                         input logic [62:0] lit, input bit use_lit);
    logic [62:0] w;
    int e;
    exp_q.push_back(use_lit ? lit : gen_word(k, seed));
    @(posedge clk); #2;
    bus.req_valid = 1'b1;
    bus.req_k     = 6'(k);
    bus.req_seed  = 6'(seed);
    e = cyc;
    @(posedge clk); #2;
    bus.req_valid = 1'b0;
    @(negedge clk);
    while (!bus.out_valid && cyc < e + 200) @(negedge clk);
    w = exp_q.pop_front();
    check("valid_seen", bus.out_valid, 1'b1);
    check("latency", 64'(cyc - e), 64'(k + 1));
    check("word", bus.out_word, w);
    check("k_echo", bus.out_k, 64'(k));
    check("popcount", 64'($countones(bus.out_word)), 64'(k));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid", bus.out_valid, 1'b1);
      check("stall_word", bus.out_word, w);
      check("stall_req_ready", bus.req_ready, 1'b0);
    end
    @(posedge clk); #2;
    bus.out_ready = 1'b1;
    @(posedge clk); #2;
    bus.out_ready = 1'b0;
  endtask

  int seeds [4] = '{1, 0, 42, 63};

  initial begin
    bus.req_valid = 1'b0;
    bus.req_k     = '0;
    bus.req_seed  = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_out_word", bus.out_word, 63'h0);
    check("rst_out_k", bus.out_k, 6'd0);

    check("model_k6", gen_word(6, 1), 63'h1_0000_808B);
    check("model_k63", gen_word(63, 0), {63{1'b1}});

    run_req(3, 1, 0, 63'h0000_0000_0000_000B, 1'b1);
    run_req(6, 1, 0, 63'h0000_0001_0000_808B, 1'b1);
    run_req(0, 17, 0, 63'h0, 1'b1);
    run_req(63, 0, 0, {63{1'b1}}, 1'b1);
    run_req(5, 1, 10, 63'h0000_0000_0000_808B, 1'b1);

    // Reset pulse in the middle of a K=40 fill.
    @(posedge clk); #2;
    bus.req_valid = 1'b1;
    bus.req_k     = 6'd40;
    bus.req_seed  = 6'd5;
    @(posedge clk); #2;
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_req_ready", bus.req_ready, 1'b1);
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_out_word", bus.out_word, 63'h0);
    check("midrst_out_k", bus.out_k, 6'd0);

    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 64; k++) begin
        run_req(k, seeds[s], 0, 63'h0, 1'b0);
      end
    end

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    bad++;
    $display("FAIL timeout: got running expected finished (cycle %0d)", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "bench timeout");
  end

endmodule
